instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port mem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port mem_resp_valid  input  1  read data valid, one per accepted request, in order.
REQ-008 SHALL have port mem_resp_data  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  taken branch/jump, flush and refetch.
REQ-010 SHALL have port redirect_target  input  32  new PC.
REQ-011 SHALL have port instr_valid  output  1  instruction presented to decode.
REQ-012 SHALL have port instr_ready  input  1  decode consumes instruction.
REQ-013 SHALL have port instruction  output  32  instruction word to decode.
REQ-014 SHALL have port instr_pc  output  32  PC of presented instruction.
REQ-015 SHALL have port fetch_error  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL hold fetch_pc register; request handshake = mem_req_valid & mem_req_ready; each handshake advances fetch_pc by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-017 SHALL allow at most one outstanding request; mem_req_valid asserted only when no request outstanding, not halted, and buffer occupancy < 2.
REQ-018 SHALL keep mem_req_addr = fetch_pc and hold valid/addr stable until handshake, except on redirect.
REQ-019 SHALL buffer {pc, word} in 2-entry FIFO; instr_valid = FIFO non-empty; instruction/instr_pc = head entry; pop on instr_valid & instr_ready.
REQ-020 SHALL push a response in the cycle mem_resp_valid is high (tagged with its request PC), unless discarded; response latency >= 1 cycle; earliest instr_valid is the cycle after response (2 cycles after request handshake minimum).
REQ-021 SHALL support simultaneous push and pop when FIFO full or non-empty, occupancy unchanged.
REQ-022 SHALL use FSM states: RUN (may issue), WAIT (one outstanding), DRAIN (outstanding response to discard), HALT (error).
REQ-023 SHALL transition RUN->WAIT on request handshake; WAIT->RUN on mem_resp_valid; WAIT->DRAIN on redirect without same-cycle response; DRAIN->RUN on mem_resp_valid, discarding it.
REQ-024 On redirect_valid SHALL: flush FIFO (same-cycle pop ignored), set fetch_pc = redirect_target, deassert mem_req_valid that cycle, and discard any response arriving that cycle.
REQ-025 Redirect SHALL take priority over push, pop and request; first redirected request issues no earlier than the cycle after redirect.
REQ-026 Redirect in DRAIN SHALL update fetch_pc, remain in DRAIN; latest target wins.

Reset
REQ-027 On reset SHALL set fetch_pc = RESET_VECTOR, FIFO empty, state RUN, fetch_error = 0.
REQ-028 During reset cycle outputs SHALL be mem_req_valid = 0, instr_valid = 0, fetch_error = 0; instruction and instr_pc = 0.
REQ-029 Reset mid-operation SHALL discard outstanding request; memory must also be reset, any later stray response is undefined.

Configuration
REQ-030 With FETCH_ALIGN_CHECK_EN defined, redirect_target[1:0] != 0 SHALL set fetch_error, flush FIFO, enter HALT (no further requests) until reset; pending response still discarded.
REQ-031 Without FETCH_ALIGN_CHECK_EN, redirect_target[1:0] SHALL be forced to 2'b00; fetch_error tied 0; HALT unreachable.

Verification
REQ-032 Reset, mem always ready, 1-cycle latency, instr_ready=1 -> requests to 0x0,0x4,0x8; instr_pc sequence 0x0,0x4,0x8 with matching words.
REQ-033 instr_ready=0 for 10 cycles -> exactly 2 entries buffered, mem_req_valid low; release -> entries drain in order, no loss or duplicates.
REQ-034 Redirect to 0x100 while request to 0x8 outstanding (response 3 cycles later) -> response discarded, next instr_pc = 0x100, no 0x8 seen.
REQ-035 fetch_pc = 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-036 With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_error=1 next cycle, instr_valid=0, no requests until reset; without macro -> fetch at 0x100.
REQ-037 Redirect same cycle as pop and response -> FIFO empty next cycle, response dropped, next request to target.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues word-aligned fetch requests with at most one
// outstanding, buffers {pc, word} pairs in a 2-entry FIFO toward decode, and
// handles redirects by flushing the FIFO and discarding the in-flight response.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned redirect target
// sets a sticky fetch_error and halts fetching until reset. When the macro is
// undefined, the target's low two bits are forced to zero and fetch_error is 0.
module instruction_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        fetch_error
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_entry_t;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   req_pc_q, req_pc_d;
   fetch_entry_t      fifo_q [DEPTH];
   fetch_entry_t      fifo_d [DEPTH];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              req_valid_c;
   logic              redirect_c;
   logic              push_c;
   logic              pop_c;
   logic              misaligned_c;
   logic [XLEN-1:0]   target_c;
   fetch_entry_t      head_c;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned_c = (redirect_target[1:0] != 2'b00);
   assign target_c     = redirect_target;
`else
   assign misaligned_c = 1'b0;
   assign target_c     = redirect_target & 32'hFFFF_FFFC;
`endif

   // Next-state, FIFO control and request generation; redirect outranks all else.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      fifo_d      = fifo_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      redirect_c  = redirect_valid && (state_q != ST_HALT);
      req_valid_c = !reset && (state_q == ST_RUN) &&
                    (count_q != CNT_W'(DEPTH)) && !redirect_valid;

      case (state_q)
         ST_RUN: begin
            if (redirect_c) begin
               state_d = misaligned_c ? ST_HALT : ST_RUN;
            end else if (req_valid_c && mem_req_ready) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + XLEN'(4);
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT, ST_DRAIN: begin
            if (redirect_c) begin
               if (misaligned_c)        state_d = ST_HALT;
               else if (mem_resp_valid) state_d = ST_RUN;
               else                     state_d = ST_DRAIN;
            end else if (mem_resp_valid) begin
               push_c  = (state_q == ST_WAIT);
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase

      if (redirect_c) begin
         fetch_pc_d = target_c;
      end

      pop_c = (count_q != '0) && instr_ready && !redirect_c;

      if (redirect_c) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = '0;
      end else begin
         if (push_c) begin
            fifo_d[wr_ptr_q] = '{pc: req_pc_q, word: mem_resp_data};
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   // State, PC and FIFO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_VECTOR;
         req_pc_q   <= '0;
         fifo_q     <= '{default: '0};
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         fifo_q     <= fifo_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic error_q;

   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (redirect_c && misaligned_c) begin
         error_q <= 1'b1;
      end
   end

   assign fetch_error = !reset && error_q;
`else
   assign fetch_error = 1'b0;
`endif

   assign head_c        = fifo_q[rd_ptr_q];
   assign mem_req_valid = req_valid_c;
   assign mem_req_addr  = fetch_pc_q;
   assign instr_valid   = !reset && (count_q != '0);
   assign instruction   = instr_valid ? head_c.word : '0;
   assign instr_pc      = instr_valid ? head_c.pc   : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with an abstract reference model
// (PC counter, outstanding flag, discard flag, queue of buffered entries) and
// a memory model that answers every accepted request in order.
module tb_instruction_fetch;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid, instr_ready;
   logic [31:0] instruction, instr_pc;
   logic        fetch_error;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_VECTOR(RV)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instruction     (instruction),
      .instr_pc        (instr_pc),
      .fetch_error     (fetch_error)
   );

   // Reference model state
   logic [31:0] m_pc, m_req_pc;
   bit          m_out, m_drain, m_halt, m_err;
   logic [63:0] m_q[$];

   // Memory model
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   int cyc, n_cmp, n_fail;
   int p_rdy, p_irdy, p_redir, p_rst, lat_fix, rst_hold;

   bit          s_hs, s_pop, s_req_valid, s_instr_valid, s_err;
   logic [31:0] s_addr, s_pc;
   logic [31:0] req_log[$], pop_pc_log[$], pop_w_log[$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event never happened within budget (cycle %0d)", name, cyc);
   endtask

   function automatic bit e_req_valid();
      return !reset && !m_halt && !m_out && (m_q.size() < 2) && !redirect_valid;
   endfunction

   function automatic logic [31:0] gen_target();
      logic [31:0] t;
      t = $urandom;
      case ($urandom_range(3))
         0: t = 32'hFFFF_FFE0 | (t & 32'h1F);
         1: t = t & 32'h0000_03FF;
         default: ;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
`endif
      return t;
   endfunction

   // Compare DUT outputs against the model away from the clock edge.
   task automatic compare_now();
      bit ev, eiv;
      ev  = e_req_valid();
      eiv = !reset && (m_q.size() > 0);
      chk("mem_req_valid", 32'(mem_req_valid), 32'(ev));
      if (ev) chk("mem_req_addr", mem_req_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(eiv));
      if (eiv) begin
         chk("instr_pc", instr_pc, m_q[0][63:32]);
         chk("instruction", instruction, m_q[0][31:0]);
      end
      if (reset) begin
         chk("reset_instr_pc", instr_pc, 32'h0);
         chk("reset_instruction", instruction, 32'h0);
      end
      chk("fetch_error", 32'(fetch_error), 32'(!reset && m_err));
      s_hs          = mem_req_valid && mem_req_ready;
      s_addr        = mem_req_addr;
      s_pop         = instr_valid && instr_ready;
      s_req_valid   = mem_req_valid;
      s_instr_valid = instr_valid;
      s_pc          = instr_pc;
      s_err         = fetch_error;
      if (s_hs) req_log.push_back(mem_req_addr);
      if (s_pop) begin
         pop_pc_log.push_back(instr_pc);
         pop_w_log.push_back(instruction);
      end
   endtask

   task automatic model_update();
      bit hs, rs, mis;
      logic [31:0] tgt;
      if (reset) begin
         m_pc = RV; m_out = 0; m_drain = 0; m_halt = 0; m_err = 0;
         m_q.delete();
      end else if (!m_halt) begin
         hs = e_req_valid() && mem_req_ready;
         rs = mem_resp_valid && m_out;
         if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            mis = (redirect_target[1:0] != 2'b00);
            tgt = redirect_target;
`else
            mis = 1'b0;
            tgt = {redirect_target[31:2], 2'b00};
`endif
            m_q.delete();
            if (mis) begin
               m_err = 1; m_halt = 1; m_out = 0; m_drain = 0;
            end else begin
               m_pc = tgt;
               if (m_out) begin
                  if (rs) begin m_out = 0; m_drain = 0; end
                  else m_drain = 1;
               end
            end
         end else begin
            if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
            if (rs) begin
               if (!m_drain) m_q.push_back({m_req_pc, mem_resp_data});
               m_out = 0; m_drain = 0;
            end
            if (hs) begin
               m_req_pc = m_pc;
               m_pc     = m_pc + 32'd4;
               m_out    = 1;
            end
         end
      end
   endtask

   task automatic mem_update();
      int lat;
      if (reset) begin
         mq_addr.delete();
         mq_due.delete();
      end else begin
         if (mem_resp_valid && mq_addr.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (s_hs) begin
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(4, 1));
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat - 1);
         end
      end
   endtask

   task automatic drive();
      if (rst_hold > 0) begin
         reset = 1'b1;
         rst_hold--;
      end else begin
         reset = int'($urandom_range(999)) < p_rst;
      end
      mem_req_ready   = int'($urandom_range(99)) < p_rdy;
      instr_ready     = int'($urandom_range(99)) < p_irdy;
      redirect_valid  = int'($urandom_range(99)) < p_redir;
      redirect_target = gen_target();
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = memword(mq_addr[0]);
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = $urandom;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_now();
      @(posedge clk);
      cyc++;
      model_update();
      mem_update();
      #1;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      run(1);
   endtask

   task automatic clear_logs();
      req_log.delete();
      pop_pc_log.delete();
      pop_w_log.delete();
   endtask

   initial begin
      logic [31:0] head;
      bit          got, saw8;
      n_cmp = 0; n_fail = 0; cyc = 0;
      p_rdy = 100; p_irdy = 100; p_redir = 0; p_rst = 0; lat_fix = 1; rst_hold = 1;
      m_pc = RV; m_req_pc = '0; m_out = 0; m_drain = 0; m_halt = 0; m_err = 0;
      reset = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      redirect_valid = 1'b0; redirect_target = '0;

      // Basic sequential fetch from reset
      run(2);
      clear_logs();
      run(12);
      if (req_log.size() >= 3 && pop_pc_log.size() >= 3) begin
         chk("seq_req0", req_log[0], 32'h0);
         chk("seq_req1", req_log[1], 32'h4);
         chk("seq_req2", req_log[2], 32'h8);
         chk("seq_pc0", pop_pc_log[0], 32'h0);
         chk("seq_pc1", pop_pc_log[1], 32'h4);
         chk("seq_pc2", pop_pc_log[2], 32'h8);
         chk("seq_w0", pop_w_log[0], 32'hDEAD_BEEF);
         chk("seq_w1", pop_w_log[1], 32'hDEAD_BEEB);
         chk("seq_w2", pop_w_log[2], 32'hDEAD_BEE7);
      end else begin
         chk("seq_count", 32'(pop_pc_log.size()), 32'd3);
      end

      // Decode stall: buffer fills to two, requests stop, then drains in order
      p_irdy = 0;
      run(10);
      chk("stall_depth", 32'(m_q.size()), 32'd2);
      chk("stall_req_valid", 32'(s_req_valid), 32'd0);
      chk("stall_instr_valid", 32'(s_instr_valid), 32'd1);
      head = s_pc;
      p_irdy = 100;
      clear_logs();
      run(10);
      if (pop_pc_log.size() >= 4) begin
         chk("drain_first", pop_pc_log[0], head);
         for (int i = 1; i < pop_pc_log.size(); i++)
            chk("drain_order", pop_pc_log[i], pop_pc_log[i-1] + 32'd4);
      end else begin
         chk("drain_count", 32'(pop_pc_log.size()), 32'd4);
      end

      // Redirect while the request to 0x8 is outstanding (latency 3)
      do_reset();
      lat_fix = 3;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (s_hs && s_addr == 32'h8) got = 1;
      end
      if (!got) timeout("wait_req_0x8");
      redirect_valid = 1'b1; redirect_target = 32'h100;
      step();
      clear_logs();
      run(14);
      saw8 = 0;
      foreach (pop_pc_log[i]) if (pop_pc_log[i] == 32'h8) saw8 = 1;
      chk("drain_no_0x8", 32'(saw8), 32'd0);
      if (pop_pc_log.size() > 0) chk("redirect_first_pc", pop_pc_log[0], 32'h100);
      else timeout("redirect_first_pc");

      // PC wrap at the top of the address space
      lat_fix = 1;
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      clear_logs();
      run(10);
      if (req_log.size() >= 2) begin
         chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
         chk("wrap_req1", req_log[1], 32'h0000_0000);
      end else begin
         chk("wrap_count", 32'(req_log.size()), 32'd2);
      end

      // Misaligned redirect target
      redirect_valid = 1'b1; redirect_target = 32'h102;
      step();
      clear_logs();
`ifdef FETCH_ALIGN_CHECK_EN
      step();
      chk("align_error", 32'(s_err), 32'd1);
      chk("align_instr_valid", 32'(s_instr_valid), 32'd0);
      run(10);
      chk("align_no_requests", 32'(req_log.size()), 32'd0);
`else
      run(8);
      if (req_log.size() >= 1) chk("align_forced_addr", req_log[0], 32'h100);
      else timeout("align_forced_addr");
`endif
      do_reset();

      // Redirect coinciding with a pop and a response
      lat_fix = 2;
      p_irdy = 0;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (mem_resp_valid && m_q.size() > 0) got = 1;
      end
      if (!got) timeout("wait_resp_with_entry");
      p_irdy = 100;
      instr_ready = 1'b1;
      redirect_valid = 1'b1; redirect_target = 32'h200;
      step();
      clear_logs();
      step();
      chk("coinc_empty", 32'(s_instr_valid), 32'd0);
      chk("coinc_req_valid", 32'(s_req_valid), 32'd1);
      chk("coinc_req_addr", s_addr, 32'h200);
      run(6);
      if (pop_pc_log.size() > 0) chk("coinc_first_pc", pop_pc_log[0], 32'h200);
      else timeout("coinc_first_pc");

      // Randomized traffic with redirects and occasional resets
      do_reset();
      p_rdy = 70; p_irdy = 70; p_redir = 4; p_rst = 8; lat_fix = 0;
      run(4000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
